// File: rtl/axi_lite_sched_pkg.sv
// axi_lite_sched_pkg - shared types and round-robin helper for the AXI-Lite transaction scheduler.
// Rev 1.0
`default_nettype none

package axi_lite_sched_pkg;

  localparam int MAX_MASTERS = 8;
  localparam int IDX_MAX_W   = $clog2(MAX_MASTERS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2
  } sched_state_e;

  typedef struct packed {
    logic                 found;
    logic [IDX_MAX_W-1:0] idx;
  } rr_pick_t;

  // First requester strictly after last_idx, wrapping modulo num.
  function automatic rr_pick_t rr_pick(
    input logic [MAX_MASTERS-1:0] req,
    input logic [IDX_MAX_W-1:0]   last_idx,
    input int                     num
  );
    rr_pick_t res;
    int       cand;
    res = '0;
    for (int k = 1; k <= MAX_MASTERS; k++) begin
      cand = (int'(last_idx) + k) % num;
      if (k <= num && !res.found && req[cand[IDX_MAX_W-1:0]]) begin
        res.found = 1'b1;
        res.idx   = cand[IDX_MAX_W-1:0];
      end
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/axi_lite_sched_engine.sv
// axi_lite_sched_engine - one transaction engine (IDLE/ADDR/RESP) with round-robin pointer and
// optional response timer (AXI_LITE_SCHED_TIMEOUT_EN). Rev 1.0
`default_nettype none

module axi_lite_sched_engine
  import axi_lite_sched_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
`ifdef AXI_LITE_SCHED_TIMEOUT_EN
  parameter int TIMEOUT_CYCLES = 256,
`endif
  parameter int IDX_W          = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] req,
  input  logic                   addr_hs,
  input  logic                   resp_hs,
  output logic [NUM_MASTERS-1:0] gnt,
  output logic                   gnt_vld,
  output logic [IDX_W-1:0]       gnt_idx,
  output logic                   timeout
);

  sched_state_e           state, state_n;
  logic [NUM_MASTERS-1:0] gnt_n;
  logic                   vld_n;
  logic [IDX_W-1:0]       idx_n;
  logic [IDX_W-1:0]       last_idx, last_n;
  rr_pick_t               pick;
  logic                   expire;

`ifdef AXI_LITE_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt;
  logic             timeout_n;

  // Counter sits at zero in IDLE, so it starts from zero on every ADDR entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                cnt <= '0;
    else if (state == IDLE) cnt <= '0;
    else                    cnt <= cnt + 1'b1;
  end

  assign expire = (state != IDLE) && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) timeout <= 1'b0;
    else     timeout <= timeout_n;
  end
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      gnt_vld  <= 1'b0;
      gnt_idx  <= '0;
      last_idx <= IDX_W'(NUM_MASTERS - 1);
    end else begin
      state    <= state_n;
      gnt      <= gnt_n;
      gnt_vld  <= vld_n;
      gnt_idx  <= idx_n;
      last_idx <= last_n;
    end
  end

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    vld_n   = gnt_vld;
    idx_n   = gnt_idx;
    last_n  = last_idx;
`ifdef AXI_LITE_SCHED_TIMEOUT_EN
    timeout_n = 1'b0;
`endif
    pick    = rr_pick(MAX_MASTERS'(req), IDX_MAX_W'(last_idx), NUM_MASTERS);

    case (state)
      IDLE: begin
        if (pick.found) begin
          state_n = ADDR;
          vld_n   = 1'b1;
          idx_n   = IDX_W'(pick.idx);
          gnt_n   = NUM_MASTERS'(1) << pick.idx;
        end
      end
      ADDR: begin
        if (addr_hs) state_n = RESP;
      end
      RESP: begin
        if (resp_hs) begin
          state_n = IDLE;
          gnt_n   = '0;
          vld_n   = 1'b0;
          last_n  = gnt_idx;
        end
      end
      default: state_n = IDLE;
    endcase

    // A response landing on the expiry cycle wins over the timeout.
    if (expire && !(state == RESP && resp_hs)) begin
      state_n = IDLE;
      gnt_n   = '0;
      vld_n   = 1'b0;
      last_n  = gnt_idx;
`ifdef AXI_LITE_SCHED_TIMEOUT_EN
      timeout_n = 1'b1;
`endif
    end
  end

endmodule

`default_nettype wire

// File: rtl/axi_lite_txn_sched.sv
// axi_lite_txn_sched - independent write/read round-robin transaction schedulers for a shared
// AXI-Lite slave; timeout enabled by AXI_LITE_SCHED_TIMEOUT_EN. Rev 1.0
`default_nettype none

module axi_lite_txn_sched
  import axi_lite_sched_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int IDX_W          = (NUM_MASTERS > 2) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] wr_req,
  input  logic [NUM_MASTERS-1:0] rd_req,
  input  logic                   aw_hs,
  input  logic                   b_hs,
  input  logic                   ar_hs,
  input  logic                   r_hs,
  output logic [NUM_MASTERS-1:0] wr_gnt,
  output logic                   wr_gnt_vld,
  output logic [IDX_W-1:0]       wr_gnt_idx,
  output logic [NUM_MASTERS-1:0] rd_gnt,
  output logic                   rd_gnt_vld,
  output logic [IDX_W-1:0]       rd_gnt_idx,
  output logic                   wr_timeout,
  output logic                   rd_timeout
);

  generate
    if (NUM_MASTERS < 2 || NUM_MASTERS > MAX_MASTERS) begin : g_bad_num_masters
      $error("axi_lite_txn_sched: NUM_MASTERS must be in 2..8");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("axi_lite_txn_sched: TIMEOUT_CYCLES must be >= 2");
    end
  endgenerate

  axi_lite_sched_engine #(
    .NUM_MASTERS    (NUM_MASTERS),
`ifdef AXI_LITE_SCHED_TIMEOUT_EN
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
`endif
    .IDX_W          (IDX_W)
  ) u_wr_engine (
    .clk     (clk),
    .rst     (rst),
    .req     (wr_req),
    .addr_hs (aw_hs),
    .resp_hs (b_hs),
    .gnt     (wr_gnt),
    .gnt_vld (wr_gnt_vld),
    .gnt_idx (wr_gnt_idx),
    .timeout (wr_timeout)
  );

  axi_lite_sched_engine #(
    .NUM_MASTERS    (NUM_MASTERS),
`ifdef AXI_LITE_SCHED_TIMEOUT_EN
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
`endif
    .IDX_W          (IDX_W)
  ) u_rd_engine (
    .clk     (clk),
    .rst     (rst),
    .req     (rd_req),
    .addr_hs (ar_hs),
    .resp_hs (r_hs),
    .gnt     (rd_gnt),
    .gnt_vld (rd_gnt_vld),
    .gnt_idx (rd_gnt_idx),
    .timeout (rd_timeout)
  );

endmodule

`default_nettype wire

// File: tb/tb_axi_lite_txn_sched.sv
// tb_axi_lite_txn_sched - directed self-checking bench for axi_lite_txn_sched (2 masters, timeout 16).
// Rev 1.0
`default_nettype none

module tb_axi_lite_txn_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] wr_req, rd_req;
  logic       aw_hs, b_hs, ar_hs, r_hs;
  logic [1:0] wr_gnt, rd_gnt;
  logic       wr_gnt_vld, rd_gnt_vld;
  logic [0:0] wr_gnt_idx, rd_gnt_idx;
  logic       wr_timeout, rd_timeout;

  int checks   = 0;
  int failures = 0;

  axi_lite_txn_sched #(
    .NUM_MASTERS    (2),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_req     (wr_req),
    .rd_req     (rd_req),
    .aw_hs      (aw_hs),
    .b_hs       (b_hs),
    .ar_hs      (ar_hs),
    .r_hs       (r_hs),
    .wr_gnt     (wr_gnt),
    .wr_gnt_vld (wr_gnt_vld),
    .wr_gnt_idx (wr_gnt_idx),
    .rd_gnt     (rd_gnt),
    .rd_gnt_vld (rd_gnt_vld),
    .rd_gnt_idx (rd_gnt_idx),
    .wr_timeout (wr_timeout),
    .rd_timeout (rd_timeout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compares {timeout, vld, idx (only meaningful while vld), gnt} against a one-hot expectation.
  task automatic chk(input string tag, input logic is_rd, input logic [1:0] eg, input logic et);
    logic [4:0] obs, exp;
    if (is_rd) obs = {rd_timeout, rd_gnt_vld, rd_gnt_vld ? rd_gnt_idx[0] : 1'b0, rd_gnt};
    else       obs = {wr_timeout, wr_gnt_vld, wr_gnt_vld ? wr_gnt_idx[0] : 1'b0, wr_gnt};
    exp = {et, |eg, eg[1], eg};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_idx0(input string tag);
    checks++;
    assert ({wr_gnt_idx, rd_gnt_idx} === 2'b00) else begin
      failures++;
      $error("FAIL %s observed=%b expected=00", tag, {wr_gnt_idx, rd_gnt_idx});
    end
  endtask

  // Write transaction starting from a visible grant in ADDR; ends one cycle after release.
  task automatic wr_txn(input string tag, input logic [1:0] eg);
    chk({tag, "_gnt"}, 1'b0, eg, 1'b0);
    aw_hs = 1'b1; step(); aw_hs = 1'b0;
    chk({tag, "_resp_hold"}, 1'b0, eg, 1'b0);
    b_hs = 1'b1; step(); b_hs = 1'b0;
    chk({tag, "_bubble"}, 1'b0, 2'b00, 1'b0);
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1; step(); step();
    #2 rst = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1; wr_req = '0; rd_req = '0;
    aw_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
    step(); step();
    chk("rst_wr", 1'b0, 2'b00, 1'b0);
    chk("rst_rd", 1'b1, 2'b00, 1'b0);
    chk_idx0("rst_idx");
    #2 rst = 1'b0;
    step();

    // 1: reset mid-run, release with no requests
    wr_req = 2'b11; step();
    chk("t1_pre", 1'b0, 2'b01, 1'b0);
    #2 rst = 1'b1; #1;
    chk("t1_async", 1'b0, 2'b00, 1'b0);
    wr_req = 2'b00;
    step();
    chk("t1_during_rd", 1'b1, 2'b00, 1'b0);
    #2 rst = 1'b0;
    step(); step();
    chk("t1_after_wr", 1'b0, 2'b00, 1'b0);
    chk("t1_after_rd", 1'b1, 2'b00, 1'b0);
    chk_idx0("t1_idx");

    // 2: basic write timeline, both masters requesting
    wr_req = 2'b11; step();                        // cycle 1
    chk("t2_c1", 1'b0, 2'b01, 1'b0);
    b_hs = 1'b1; step(); b_hs = 1'b0;              // cycle 2, b_hs in ADDR ignored
    chk("t2_c2_resp_in_addr", 1'b0, 2'b01, 1'b0);
    step();                                        // cycle 3
    aw_hs = 1'b1; step(); aw_hs = 1'b0;            // cycle 4
    chk("t2_c4", 1'b0, 2'b01, 1'b0);
    step(); step();                                // cycle 6
    chk("t2_c6", 1'b0, 2'b01, 1'b0);
    b_hs = 1'b1; step(); b_hs = 1'b0;              // cycle 7
    chk("t2_c7", 1'b0, 2'b00, 1'b0);
    step();                                        // cycle 8
    chk("t2_c8", 1'b0, 2'b10, 1'b0);

    // addr and resp handshakes together in ADDR: only the address is taken
    aw_hs = 1'b1; b_hs = 1'b1; step(); aw_hs = 1'b0; b_hs = 1'b0;
    chk("t2_same_cycle", 1'b0, 2'b10, 1'b0);
    step();
    chk("t2_same_cycle_hold", 1'b0, 2'b10, 1'b0);
    b_hs = 1'b1; step(); b_hs = 1'b0;
    chk("t2_release", 1'b0, 2'b00, 1'b0);
    step();

    // 3: four back-to-back transactions alternate 0,1,0,1
    wr_txn("t3_a", 2'b01);
    wr_txn("t3_b", 2'b10);
    wr_txn("t3_c", 2'b01);
    wr_txn("t3_d", 2'b10);
    chk("t3_next", 1'b0, 2'b01, 1'b0);

    // single requester is re-granted every transaction
    wr_req = 2'b01;
    wr_txn("t3_single_a", 2'b01);
    wr_txn("t3_single_b", 2'b01);
    wr_req = 2'b00;
    do_reset();

    // 4: concurrent write and read grants
    wr_req = 2'b01; rd_req = 2'b10; step();
    chk("t4_wr", 1'b0, 2'b01, 1'b0);
    chk("t4_rd", 1'b1, 2'b10, 1'b0);
    ar_hs = 1'b1; step(); ar_hs = 1'b0;
    r_hs = 1'b1; step(); r_hs = 1'b0;
    chk("t4_rd_done", 1'b1, 2'b00, 1'b0);
    chk("t4_wr_undisturbed", 1'b0, 2'b01, 1'b0);
    rd_req = 2'b00;
    wr_txn("t4_wr_finish", 2'b01);
    wr_req = 2'b00;
    do_reset();

    // 5: reset while writing master 1 in RESP
    wr_req = 2'b10; step();
    chk("t5_gnt1", 1'b0, 2'b10, 1'b0);
    aw_hs = 1'b1; step(); aw_hs = 1'b0;
    wr_req = 2'b11;
    #2 rst = 1'b1; #1;
    chk("t5_async_drop", 1'b0, 2'b00, 1'b0);
    #2 rst = 1'b0;
    step();
    chk("t5_regrant0", 1'b0, 2'b01, 1'b0);
    wr_req = 2'b00;
    do_reset();

    // 6: address accepted, response never arrives
    wr_req = 2'b11; step();                        // cycle 1, counter 0
    chk("t6_gnt", 1'b0, 2'b01, 1'b0);
    aw_hs = 1'b1; step(); aw_hs = 1'b0;            // cycle 2
`ifdef AXI_LITE_SCHED_TIMEOUT_EN
    for (int i = 0; i < 14; i++) step();           // cycle 16, counter 15
    chk("t6_last_held", 1'b0, 2'b01, 1'b0);
    step();
    chk("t6_timeout_pulse", 1'b0, 2'b00, 1'b1);
    step();
    chk("t6_next_master", 1'b0, 2'b10, 1'b0);
`else
    for (int i = 0; i < 100; i++) begin
      step();
      chk("t6_held", 1'b0, 2'b01, 1'b0);
    end
`endif
    wr_req = 2'b00;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/axi_lite_txn_sched.md
Name: axi_lite_txn_sched

Overview:
- Transaction-level round-robin scheduler for a shared AXI-Lite slave port.
- Drives grant selects for the AXI-Lite arbiter datapath mux.
- Holds each grant from address handshake through response handshake, so a response is never steered to the wrong master.
- Write (AW/W/B) and read (AR/R) paths are scheduled by two independent engines.

Parameters:
- NUM_MASTERS, 2, number of requesting masters (2..8).
- TIMEOUT_CYCLES, 256, response timeout in cycles; used only when the optional feature is compiled in.
- IDX_W, $clog2(NUM_MASTERS) with minimum 1, width of the grant index (derived; do not override).

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- rst  in  1  reset; one clock; reset is asynchronous and active-high.
- wr_req  in  NUM_MASTERS  per-master AWVALID.
- rd_req  in  NUM_MASTERS  per-master ARVALID.
- aw_hs  in  1  slave-side AWVALID&AWREADY.
- b_hs  in  1  slave-side BVALID&BREADY.
- ar_hs  in  1  slave-side ARVALID&ARREADY.
- r_hs  in  1  slave-side RVALID&RREADY.
- wr_gnt  out  NUM_MASTERS  one-hot write grant.
- wr_gnt_vld  out  1  write grant active.
- wr_gnt_idx  out  IDX_W  binary index of the write grant.
- rd_gnt  out  NUM_MASTERS  one-hot read grant.
- rd_gnt_vld  out  1  read grant active.
- rd_gnt_idx  out  IDX_W  binary index of the read grant.
- wr_timeout  out  1  one-cycle pulse on write response timeout.
- rd_timeout  out  1  one-cycle pulse on read response timeout.

Behaviour:
- Reset values: all gnt=0, gnt_vld=0, gnt_idx=0, timeout=0, both engines in IDLE, last_idx=NUM_MASTERS-1 (so master 0 wins first).
- All outputs are registered. Grant latency is 1 cycle from req seen in IDLE.
- Engine FSM: IDLE -> ADDR -> RESP -> IDLE.
- IDLE, req==0: stay in IDLE.
- IDLE, req!=0: round-robin search starting at (last_idx+1) mod NUM_MASTERS, wrapping. Register gnt, idx and vld=1; go to ADDR.
- ADDR: hold the grant until addr_hs (aw_hs / ar_hs), then go to RESP.
  - A resp_hs in ADDR is ignored (not legal AXI).
  - Requester dropping req in ADDR is a protocol violation; the grant is still held.
- RESP: hold the grant until resp_hs (b_hs / r_hs). On the next edge: gnt=0, vld=0, last_idx=granted idx, go to IDLE.
- Turnaround: minimum 1 idle bubble cycle between back-to-back transactions on one engine.
- Grant changes only in IDLE; there is no preemption.
- Write and read engines are fully independent. They may grant different or the same master concurrently.
- Boundary cases:
  - Single requester: re-granted every transaction.
  - last_idx=NUM_MASTERS-1: search wraps to 0.
  - addr_hs and resp_hs in the same cycle while in ADDR: only addr_hs is taken.
  - Reset mid-transaction: immediate asynchronous return to the reset values, with no completion.

Optional Feature:
- Macro: AXI_LITE_SCHED_TIMEOUT_EN.
- Defined:
  - Per-engine counter, width $clog2(TIMEOUT_CYCLES+1); cleared on IDLE->ADDR entry, increments each cycle in ADDR or RESP.
  - If the count reaches TIMEOUT_CYCLES-1 without completion: pulse *_timeout for 1 cycle, force IDLE, drop the grant on the same edge, and update last_idx.
  - Completion in the same cycle as expiry counts as completion; no pulse.
- Undefined:
  - No counter is built.
  - wr_timeout and rd_timeout are tied to 0.
  - The grant is held indefinitely.

Decomposition:
- Package axi_lite_sched_pkg holds:
  - sched_state_e enum {IDLE, ADDR, RESP}.
  - MAX_MASTERS=8.
  - rr_pick function (req, last_idx -> idx, found).
- Sub-module axi_lite_sched_engine: one FSM, round-robin pointer, optional timer. Instantiated twice (write, read).
- Top level: wiring and parameter checks (NUM_MASTERS in 2..8, TIMEOUT_CYCLES >= 2).

Test Plan:
1. Assert rst mid-run, then release with req=0 -> all outputs 0 during and after reset; no grant issued.
2. wr_req=2'b11 at cycle 0 -> wr_gnt=01, idx=0 at cycle 1; aw_hs cycle 3, b_hs cycle 6 -> gnt=00 cycle 7; wr_gnt=10 at cycle 8.
3. Both masters requesting continuously for 4 write transactions -> grant order 0,1,0,1, with exactly one bubble cycle between grants.
4. wr_req=01 and rd_req=10 in the same cycle -> wr_gnt=01 and rd_gnt=10 both at cycle 1; completing the read first does not disturb the write grant.
5. Reset pulse while the write engine is in RESP granting master 1 -> wr_gnt=00 immediately; after release with wr_req=11, master 0 is granted.
6. Timeout, TIMEOUT_CYCLES=16, aw_hs given, no b_hs:
   - With macro -> wr_timeout pulses 1 cycle, grant drops the next edge, then the next master is granted.
   - Without macro -> grant is held for 100 cycles and wr_timeout stays 0.
